// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined Dadda-tree multiplier with valid/ready handshaking.
// Each operation carries its own unsigned/signed (Baugh-Wooley) mode and a user tag.
module dadda_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_mode_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o,
  output logic [TAG_W-1:0]   out_tag_o,
  output logic               busy_o
);

  localparam int NCOL = 2 * WIDTH;
  localparam int MAXH = WIDTH;

  logic               advance;

  logic               s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0]   s1A_q, s1A_d;
  logic [WIDTH-1:0]   s1B_q, s1B_d;
  logic               s1Signed_q, s1Signed_d;
  logic [TAG_W-1:0]   s1Tag_q, s1Tag_d;

  logic               s2Valid_q, s2Valid_d;
  logic [NCOL-1:0]    s2RowA_q, s2RowA_d;
  logic [NCOL-1:0]    s2RowB_q, s2RowB_d;
  logic [TAG_W-1:0]   s2Tag_q, s2Tag_d;

  logic               s3Valid_q, s3Valid_d;
  logic [NCOL-1:0]    s3P_q, s3P_d;
  logic [TAG_W-1:0]   s3Tag_q, s3Tag_d;

  logic [NCOL-1:0]    rowA;
  logic [NCOL-1:0]    rowB;

  function automatic int daddaHeight(input int s);
    case (s)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 9;
      default: return 13;
    endcase
  endfunction

  // Columns are bit lists; each Dadda stage applies just enough FA/HA cells to cap
  // every column (own bits plus incoming carries) at the stage target height.
  always_comb begin : daddaTree
    logic cb [NCOL][MAXH];
    logic nb [NCOL][MAXH];
    int   cn [NCOL];
    int   nn [NCOL];
    int   k;
    int   ex;
    int   d;
    logic x, y, z;

    k = 0;
    ex = 0;
    d = 0;
    x = 1'b0;
    y = 1'b0;
    z = 1'b0;
    rowA = '0;
    rowB = '0;
    for (int c = 0; c < NCOL; c++) begin
      cn[c] = 0;
      nn[c] = 0;
      for (int h = 0; h < MAXH; h++) begin
        cb[c][h] = 1'b0;
        nb[c][h] = 1'b0;
      end
    end

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        cb[i+j][cn[i+j]] = (s1A_q[i] & s1B_q[j]) ^
                           (s1Signed_q & ((i == WIDTH-1) != (j == WIDTH-1)));
        cn[i+j]++;
      end
    end
    cb[WIDTH][cn[WIDTH]] = s1Signed_q;
    cn[WIDTH]++;
    cb[NCOL-1][cn[NCOL-1]] = s1Signed_q;
    cn[NCOL-1]++;

    for (int s = 5; s >= 0; s--) begin
      d = daddaHeight(s);
      for (int c = 0; c < NCOL; c++) begin
        nn[c] = 0;
        for (int h = 0; h < MAXH; h++) nb[c][h] = 1'b0;
      end
      for (int c = 0; c < NCOL; c++) begin
        k = 0;
        ex = cn[c] + nn[c] - d;
        for (int f = 0; f < MAXH; f++) begin
          if (ex >= 2) begin
            x = cb[c][k];
            y = cb[c][k+1];
            z = cb[c][k+2];
            nb[c][nn[c]] = x ^ y ^ z;
            nn[c]++;
            if (c < NCOL-1) begin
              nb[c+1][nn[c+1]] = (x & y) | (x & z) | (y & z);
              nn[c+1]++;
            end
            k += 3;
            ex -= 2;
          end else if (ex == 1) begin
            x = cb[c][k];
            y = cb[c][k+1];
            nb[c][nn[c]] = x ^ y;
            nn[c]++;
            if (c < NCOL-1) begin
              nb[c+1][nn[c+1]] = x & y;
              nn[c+1]++;
            end
            k += 2;
            ex = 0;
          end
        end
        for (int j = 0; j < MAXH; j++) begin
          if (j >= k && j < cn[c]) begin
            nb[c][nn[c]] = cb[c][j];
            nn[c]++;
          end
        end
      end
      cb = nb;
      cn = nn;
    end

    for (int c = 0; c < NCOL; c++) begin
      rowA[c] = cb[c][0];
      rowB[c] = cb[c][1];
    end
  end

  assign advance     = !s3Valid_q || out_ready_i;
  assign in_ready_o  = advance;
  assign out_valid_o = s3Valid_q;
  assign p_o         = s3P_q;
  assign out_tag_o   = s3Tag_q;
  assign busy_o      = s1Valid_q | s2Valid_q | s3Valid_q;

  // The whole pipe moves as one; a stall freezes every stage, bubbles included.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1Signed_d = s1Signed_q;
    s1Tag_d    = s1Tag_q;
    s2Valid_d  = s2Valid_q;
    s2RowA_d   = s2RowA_q;
    s2RowB_d   = s2RowB_q;
    s2Tag_d    = s2Tag_q;
    s3Valid_d  = s3Valid_q;
    s3P_d      = s3P_q;
    s3Tag_d    = s3Tag_q;
    if (advance) begin
      s1Valid_d = in_valid_i;
      if (in_valid_i) begin
        s1A_d      = a_i;
        s1B_d      = b_i;
        s1Signed_d = signed_mode_i;
        s1Tag_d    = in_tag_i;
      end
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2RowA_d = rowA;
        s2RowB_d = rowB;
        s2Tag_d  = s1Tag_q;
      end
      s3Valid_d = s2Valid_q;
      if (s2Valid_q) begin
        s3P_d   = s2RowA_q + s2RowB_q;
        s3Tag_d = s2Tag_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Signed_q <= 1'b0;
      s1Tag_q    <= '0;
      s2Valid_q  <= 1'b0;
      s2RowA_q   <= '0;
      s2RowB_q   <= '0;
      s2Tag_q    <= '0;
      s3Valid_q  <= 1'b0;
      s3P_q      <= '0;
      s3Tag_q    <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Signed_q <= s1Signed_d;
      s1Tag_q    <= s1Tag_d;
      s2Valid_q  <= s2Valid_d;
      s2RowA_q   <= s2RowA_d;
      s2RowB_q   <= s2RowB_d;
      s2Tag_q    <= s2Tag_d;
      s3Valid_q  <= s3Valid_d;
      s3P_q      <= s3P_d;
      s3Tag_q    <= s3Tag_d;
    end
  end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Bench for dadda_mult_pipe: directed vectors, backpressure and mid-stream reset on
// an 8-bit instance, plus random streams against a golden model at several widths.
`timescale 1ns/1ps
module tb_dadda_mult_pipe;

  localparam int W     = 8;
  localparam int TW    = 4;
  localparam int NRAND = 10000;

  typedef struct {
    logic [2*W-1:0] p;
    logic [TW-1:0]  tag;
    int             issueCycle;
  } expT;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [TW-1:0]  tag;
    logic [2*W-1:0] p;
  } vecT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycle       = 0;
  int popCount    = 0;
  int stallCount  = 0;
  int rndFinished = 0;
  bit checkLatency = 1'b0;
  logic startRandom = 1'b0;

  logic           rst;
  logic           inValid;
  logic           inReady;
  logic [W-1:0]   inA;
  logic [W-1:0]   inB;
  logic           inSm;
  logic [TW-1:0]  inTag;
  logic           outValid;
  logic           outReady;
  logic [2*W-1:0] p;
  logic [TW-1:0]  outTag;
  logic           busy;
  logic [2*W-1:0] curExpP;

  expT expQ [$];
  vecT vecs [13];
  vecT bpOps [6];

  dadda_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (inValid),
    .in_ready_o    (inReady),
    .a_i           (inA),
    .b_i           (inB),
    .signed_mode_i (inSm),
    .in_tag_i      (inTag),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .p_o           (p),
    .out_tag_o     (outTag),
    .busy_o        (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s", name);
  endtask

  // One clock of the 8-bit bench: settle, score the output, log an accepted input.
  task automatic cycleStep(output bit accepted);
    expT e;
    accepted = 1'b0;
    #1;
    if (outValid && !outReady) begin
      stallCount++;
      checkOutput("stall_in_ready", 32'(inReady), 32'd0);
      if (expQ.size() > 0) checkOutput("stall_p_hold", 32'(p), 32'(expQ[0].p));
    end
    if (outValid && outReady) begin
      popCount++;
      if (expQ.size() == 0) begin
        failNow($sformatf("spurious_output p=%0h tag=%0h", p, outTag));
      end else begin
        e = expQ.pop_front();
        checkOutput("p", 32'(p), 32'(e.p));
        checkOutput("out_tag", 32'(outTag), 32'(e.tag));
        if (checkLatency) checkOutput("latency", 32'(cycle - e.issueCycle), 32'd3);
      end
    end
    if (inValid && inReady) begin
      e.p = curExpP;
      e.tag = inTag;
      e.issueCycle = cycle;
      expQ.push_back(e);
      accepted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic applyStimulus(input vecT v);
    bit acc;
    acc = 1'b0;
    inA = v.a;
    inB = v.b;
    inSm = v.sm;
    inTag = v.tag;
    curExpP = v.p;
    inValid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) cycleStep(acc);
    if (!acc) failNow("input_accept_timeout");
  endtask

  task automatic drainPipe(input int budget);
    bit acc;
    inValid = 1'b0;
    for (int t = 0; t < budget && expQ.size() > 0; t++) cycleStep(acc);
    if (expQ.size() > 0) failNow($sformatf("drain_timeout left=%0d", expQ.size()));
    for (int t = 0; t < 3; t++) cycleStep(acc);
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : mainTest
    bit acc;
    int issued;
    int popStart;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01};
    vecs[1]  = '{8'h00, 8'hAD, 1'b0, 4'h2, 16'h0000};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 4'h3, 16'h4000};
    vecs[3]  = '{8'h80, 8'h7F, 1'b1, 4'h4, 16'hC080};
    vecs[4]  = '{8'hFF, 8'h01, 1'b1, 4'h5, 16'hFFFF};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 4'h6, 16'h0001};
    vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 4'h7, 16'h3F01};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 4'h8, 16'h4000};
    vecs[8]  = '{8'hFF, 8'h80, 1'b0, 4'h9, 16'h7F80};
    vecs[9]  = '{8'h0D, 8'h0B, 1'b0, 4'hA, 16'h008F};
    vecs[10] = '{8'hF6, 8'h07, 1'b1, 4'hB, 16'hFFBA};
    vecs[11] = '{8'h00, 8'h80, 1'b1, 4'hC, 16'h0000};
    vecs[12] = '{8'h01, 8'h80, 1'b1, 4'hD, 16'hFF80};

    bpOps[0] = '{8'h0C, 8'h0C, 1'b0, 4'h1, 16'h0090};
    bpOps[1] = '{8'hC8, 8'h03, 1'b0, 4'h2, 16'h0258};
    bpOps[2] = '{8'hFD, 8'hF9, 1'b1, 4'h3, 16'h0015};
    bpOps[3] = '{8'h64, 8'h64, 1'b0, 4'h4, 16'h2710};
    bpOps[4] = '{8'hCE, 8'h02, 1'b1, 4'h5, 16'hFF9C};
    bpOps[5] = '{8'h11, 8'h0F, 1'b0, 4'h6, 16'h00FF};

    // Reset held two cycles with a valid operation offered the whole time.
    rst = 1'b1;
    inValid = 1'b1;
    inA = 8'hFF;
    inB = 8'hFF;
    inSm = 1'b0;
    inTag = 4'hF;
    outReady = 1'b1;
    curExpP = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      cycle++;
      checkOutput("reset_out_valid", 32'(outValid), 32'd0);
      checkOutput("reset_p", 32'(p), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    inValid = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 32'(inReady), 32'd1);
    for (int i = 0; i < 5; i++) cycleStep(acc);

    $display("[TB] directed vectors, back-to-back");
    checkLatency = 1'b1;
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);
    drainPipe(20);
    checkOutput("directed_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] backpressure on cycles 4-7");
    checkLatency = 1'b0;
    issued = 0;
    popStart = popCount;
    stallCount = 0;
    for (int c = 0; c < 40 && (issued < 6 || expQ.size() > 0); c++) begin
      outReady = !(c >= 4 && c <= 7);
      if (issued < 6) begin
        inA = bpOps[issued].a;
        inB = bpOps[issued].b;
        inSm = bpOps[issued].sm;
        inTag = bpOps[issued].tag;
        curExpP = bpOps[issued].p;
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      cycleStep(acc);
      if (acc) issued++;
    end
    outReady = 1'b1;
    drainPipe(10);
    checkOutput("bp_issued", 32'(issued), 32'd6);
    checkOutput("bp_received", 32'(popCount - popStart), 32'd6);
    checkOutput("bp_stall_cycles", 32'(stallCount), 32'd4);

    $display("[TB] reset with three operations in flight");
    outReady = 1'b0;
    applyStimulus('{8'h21, 8'h43, 1'b0, 4'h1, 16'h08A3});
    applyStimulus('{8'h9A, 8'h12, 1'b1, 4'h2, 16'hF8D4});
    applyStimulus('{8'h55, 8'hAA, 1'b0, 4'h3, 16'h3872});
    rst = 1'b1;
    inValid = 1'b0;
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    cycle++;
    rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(outValid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_p", 32'(p), 32'd0);
    checkOutput("midreset_out_tag", 32'(outTag), 32'd0);
    outReady = 1'b1;
    popStart = popCount;
    for (int i = 0; i < 6; i++) cycleStep(acc);
    checkOutput("midreset_no_emit", 32'(popCount - popStart), 32'd0);
    checkLatency = 1'b1;
    applyStimulus('{8'h03, 8'h05, 1'b0, 4'hA, 16'h000F});
    drainPipe(10);
    checkLatency = 1'b0;

    $display("[TB] random streams at widths 4, 8, 13, 16");
    startRandom = 1'b1;
    for (int t = 0; t < 80000 && rndFinished < 4; t++) @(posedge clk);
    if (rndFinished < 4) failNow($sformatf("random_timeout finished=%0d", rndFinished));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : gRand
    localparam int RW = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 13 : 16;
    localparam int RT = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 7 : 16;

    logic            rRst;
    logic            rInValid;
    logic            rInReady;
    logic [RW-1:0]   rA;
    logic [RW-1:0]   rB;
    logic            rSm;
    logic [RT-1:0]   rInTag;
    logic            rOutValid;
    logic            rOutReady;
    logic [2*RW-1:0] rP;
    logic [RT-1:0]   rOutTag;
    logic            rBusy;

    logic [2*RW-1:0] expP [$];
    logic [RT-1:0]   expTag [$];

    dadda_mult_pipe #(.WIDTH(RW), .TAG_W(RT)) dut (
      .clk_i         (clk),
      .rst_i         (rRst),
      .in_valid_i    (rInValid),
      .in_ready_o    (rInReady),
      .a_i           (rA),
      .b_i           (rB),
      .signed_mode_i (rSm),
      .in_tag_i      (rInTag),
      .out_valid_o   (rOutValid),
      .out_ready_i   (rOutReady),
      .p_o           (rP),
      .out_tag_o     (rOutTag),
      .busy_o        (rBusy)
    );

    function automatic logic [2*RW-1:0] golden(input logic [RW-1:0] x,
                                               input logic [RW-1:0] y,
                                               input logic s);
      logic signed [2*RW-1:0] sx;
      logic signed [2*RW-1:0] sy;
      logic [2*RW-1:0]        ux;
      logic [2*RW-1:0]        uy;
      ux = {{RW{1'b0}}, x};
      uy = {{RW{1'b0}}, y};
      sx = {{RW{x[RW-1]}}, x};
      sy = {{RW{y[RW-1]}}, y};
      if (s) return sx * sy;
      return ux * uy;
    endfunction

    // Random stream: operands held until accepted, random bubbles and out_ready.
    initial begin : stream
      logic [31:0] r;
      bit          acc;
      int          issued;
      int          got;
      int          guard;
      string       nmP;
      string       nmT;
      nmP = $sformatf("rand_w%0d_p", RW);
      nmT = $sformatf("rand_w%0d_tag", RW);
      rRst = 1'b1;
      rInValid = 1'b0;
      rOutReady = 1'b1;
      rA = '0;
      rB = '0;
      rSm = 1'b0;
      rInTag = '0;
      issued = 0;
      got = 0;
      guard = 0;
      acc = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rRst = 1'b0;
      wait (startRandom);
      @(negedge clk);
      while (got < NRAND && guard < 60000) begin
        if (acc || !rInValid) begin
          r = $urandom();
          if (issued < NRAND && r[2:0] != 3'd0) begin
            r = $urandom();
            rA = r[RW-1:0];
            r = $urandom();
            rB = r[RW-1:0];
            r = $urandom();
            rInTag = r[RT-1:0];
            rSm = r[31];
            rInValid = 1'b1;
          end else begin
            rInValid = 1'b0;
          end
        end
        acc = 1'b0;
        r = $urandom();
        rOutReady = (r[1:0] != 2'b00);
        #1;
        if (rOutValid && rOutReady) begin
          if (expP.size() == 0) begin
            failNow($sformatf("rand_w%0d_spurious p=%0h", RW, rP));
          end else begin
            checkOutput(nmP, 32'(rP), 32'(expP.pop_front()));
            checkOutput(nmT, 32'(rOutTag), 32'(expTag.pop_front()));
          end
          got++;
        end
        if (rInValid && rInReady) begin
          expP.push_back(golden(rA, rB, rSm));
          expTag.push_back(rInTag);
          issued++;
          acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      if (got < NRAND) failNow($sformatf("rand_w%0d_timeout got=%0d", RW, got));
      rndFinished++;
    end
  end

endmodule
